// File: rtl/arcade_input_cond_pkg.sv
// Shared constants for the arcade input conditioning stage: PS/2 scan codes,
// joystick bit positions, coin FSM state encoding and counter width.
package input_cond_pkg;

  // Player 1 scan codes
  localparam logic [7:0] KC_UP        = 8'h75;
  localparam logic [7:0] KC_DOWN      = 8'h72;
  localparam logic [7:0] KC_LEFT      = 8'h6B;
  localparam logic [7:0] KC_RIGHT     = 8'h74;
  localparam logic [7:0] KC_FIRE_A    = 8'h14;
  localparam logic [7:0] KC_FIRE_B    = 8'h11;

  // Player 2 scan codes
  localparam logic [7:0] KC_P2_UP     = 8'h2D;
  localparam logic [7:0] KC_P2_DOWN   = 8'h2B;
  localparam logic [7:0] KC_P2_LEFT   = 8'h23;
  localparam logic [7:0] KC_P2_RIGHT  = 8'h34;
  localparam logic [7:0] KC_P2_FIRE_A = 8'h1C;
  localparam logic [7:0] KC_P2_FIRE_B = 8'h1B;

  // System keys; paired codes share one held-key register
  localparam logic [7:0] KC_START1_A  = 8'h05;
  localparam logic [7:0] KC_START1_B  = 8'h16;
  localparam logic [7:0] KC_START2_A  = 8'h06;
  localparam logic [7:0] KC_START2_B  = 8'h1E;
  localparam logic [7:0] KC_COIN1_A   = 8'h76;
  localparam logic [7:0] KC_COIN1_B   = 8'h2E;
  localparam logic [7:0] KC_COIN2     = 8'h36;

  // Joystick word bits; [5:0] also defines the pN_ctl layout
  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_FIRE_A = 4;
  localparam int JB_FIRE_B = 5;
  localparam int JB_START1 = 6;
  localparam int JB_START2 = 7;
  localparam int JB_COIN   = 8;

  localparam int CTL_W      = 6;
  localparam int COIN_CNT_W = 22;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } coin_state_t;

  // True when a cycle count can be loaded as (cycles-1) into the coin counter
  function automatic bit cnt_fits(input int cycles);
    return (cycles >= 1) && (cycles <= (2 ** COIN_CNT_W));
  endfunction

endpackage

// File: rtl/arcade_input_cond_coin_shaper.sv
// Coin request shaper: one fixed-width pulse per insertion, then a lockout,
// then a wait for the request to be released. Reusable per coin slot.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | armed, waiting for a coin request
// PULSE    | coin output high for PULSE_CYC cycles
// GAP      | lockout, request ignored for GAP_CYC cycles
// WAIT_REL | waiting for the request to drop (also the reset state)
module coin_shaper
  import input_cond_pkg::*;
#(
  parameter int PULSE_CYC = 400000,
  parameter int GAP_CYC   = 2000000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic creq_i,
  output logic coin_o,
  output logic coin_busy_o
);

  if (!cnt_fits(PULSE_CYC)) begin : g_bad_pulse
    $error("coin_shaper: PULSE_CYC out of range for the coin counter");
  end
  if (!cnt_fits(GAP_CYC)) begin : g_bad_gap
    $error("coin_shaper: GAP_CYC out of range for the coin counter");
  end

  localparam logic [COIN_CNT_W-1:0] PULSE_LOAD = COIN_CNT_W'(PULSE_CYC - 1);
  localparam logic [COIN_CNT_W-1:0] GAP_LOAD   = COIN_CNT_W'(GAP_CYC - 1);

  coin_state_t           state_q, state_d;
  logic [COIN_CNT_W-1:0] cnt_q, cnt_d;
  logic                  coin_q, coin_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_REL;
      cnt_q   <= '0;
      coin_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coin_q  <= coin_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (creq_i) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = WAIT_REL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_REL: begin
        if (!creq_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = WAIT_REL;
      end
    endcase
    // Outputs are registered from the next state so they change on the same
    // edge as the state itself and carry no decode glitches.
    coin_d = (state_d == PULSE);
    busy_d = (state_d != IDLE);
  end

  assign coin_o      = coin_q;
  assign coin_busy_o = busy_q;

endmodule

// File: rtl/arcade_input_cond.sv
// PS/2 key decode, joystick merge and coin shaping in front of the popeye core.
// Define COCKTAIL_SPLIT_EN to keep player 1 and player 2 controls independent.
module arcade_input_cond
  import input_cond_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 400000,
  parameter int COIN_GAP_CYC   = 2000000
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [10:0]      ps2_key,
  input  logic [15:0]      joy1,
  input  logic [15:0]      joy2,
  output logic [CTL_W-1:0] p1_ctl,
  output logic [CTL_W-1:0] p2_ctl,
  output logic             start1,
  output logic             start2,
  output logic             coin,
  output logic             coin_busy
);

  logic             old_tgl_q;
  logic             key_evt;
  logic [7:0]       key_code;
  logic             key_prs;

  logic [CTL_W-1:0] key_p1_q, key_p1_d;
  logic [CTL_W-1:0] key_p2_q, key_p2_d;
  logic             key_start1_q, key_start1_d;
  logic             key_start2_q, key_start2_d;
  logic             key_coin1_q, key_coin1_d;
  logic             key_coin2_q, key_coin2_d;

  logic [CTL_W-1:0] p1_ctl_q, p1_ctl_d;
  logic [CTL_W-1:0] p2_ctl_q, p2_ctl_d;
  logic             start1_q, start1_d;
  logic             start2_q, start2_d;
  logic [CTL_W-1:0] ctl1_raw, ctl2_raw;
  logic             creq;

  logic             unused_inputs;
  assign unused_inputs = ^{ps2_key[8], joy1[15:9], joy2[15:9]};

  assign key_evt  = ps2_key[10] ^ old_tgl_q;
  assign key_code = ps2_key[7:0];
  assign key_prs  = ps2_key[9];

  always_comb begin
    key_p1_d     = key_p1_q;
    key_p2_d     = key_p2_q;
    key_start1_d = key_start1_q;
    key_start2_d = key_start2_q;
    key_coin1_d  = key_coin1_q;
    key_coin2_d  = key_coin2_q;
    if (key_evt) begin
      case (key_code)
        KC_UP:                    key_p1_d[JB_UP]     = key_prs;
        KC_DOWN:                  key_p1_d[JB_DOWN]   = key_prs;
        KC_LEFT:                  key_p1_d[JB_LEFT]   = key_prs;
        KC_RIGHT:                 key_p1_d[JB_RIGHT]  = key_prs;
        KC_FIRE_A:                key_p1_d[JB_FIRE_A] = key_prs;
        KC_FIRE_B:                key_p1_d[JB_FIRE_B] = key_prs;
        KC_P2_UP:                 key_p2_d[JB_UP]     = key_prs;
        KC_P2_DOWN:               key_p2_d[JB_DOWN]   = key_prs;
        KC_P2_LEFT:               key_p2_d[JB_LEFT]   = key_prs;
        KC_P2_RIGHT:              key_p2_d[JB_RIGHT]  = key_prs;
        KC_P2_FIRE_A:             key_p2_d[JB_FIRE_A] = key_prs;
        KC_P2_FIRE_B:             key_p2_d[JB_FIRE_B] = key_prs;
        KC_START1_A, KC_START1_B: key_start1_d        = key_prs;
        KC_START2_A, KC_START2_B: key_start2_d        = key_prs;
        KC_COIN1_A, KC_COIN1_B:   key_coin1_d         = key_prs;
        KC_COIN2:                 key_coin2_d         = key_prs;
        default: ;
      endcase
    end
  end

  assign ctl1_raw = key_p1_q | joy1[JB_FIRE_B:JB_RIGHT];
  assign ctl2_raw = key_p2_q | joy2[JB_FIRE_B:JB_RIGHT];

  always_comb begin
`ifdef COCKTAIL_SPLIT_EN
    p1_ctl_d = ctl1_raw;
    p2_ctl_d = ctl2_raw;
`else
    // Upright cabinet: either controller drives both player inputs.
    p1_ctl_d = ctl1_raw | ctl2_raw;
    p2_ctl_d = ctl1_raw | ctl2_raw;
`endif
    start1_d = key_start1_q | joy1[JB_START1] | joy2[JB_START1];
    start2_d = key_start2_q | joy1[JB_START2] | joy2[JB_START2];
  end

  // The toggle is sampled during reset so a stale strobe level is not
  // mistaken for a key event once reset releases.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_tgl_q    <= ps2_key[10];
      key_p1_q     <= '0;
      key_p2_q     <= '0;
      key_start1_q <= 1'b0;
      key_start2_q <= 1'b0;
      key_coin1_q  <= 1'b0;
      key_coin2_q  <= 1'b0;
      p1_ctl_q     <= '0;
      p2_ctl_q     <= '0;
      start1_q     <= 1'b0;
      start2_q     <= 1'b0;
    end else begin
      old_tgl_q    <= ps2_key[10];
      key_p1_q     <= key_p1_d;
      key_p2_q     <= key_p2_d;
      key_start1_q <= key_start1_d;
      key_start2_q <= key_start2_d;
      key_coin1_q  <= key_coin1_d;
      key_coin2_q  <= key_coin2_d;
      p1_ctl_q     <= p1_ctl_d;
      p2_ctl_q     <= p2_ctl_d;
      start1_q     <= start1_d;
      start2_q     <= start2_d;
    end
  end

  assign creq = key_coin1_q | key_coin2_q | joy1[JB_COIN] | joy2[JB_COIN];

  coin_shaper #(
    .PULSE_CYC (COIN_PULSE_CYC),
    .GAP_CYC   (COIN_GAP_CYC)
  ) u_coin_shaper (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .creq_i      (creq),
    .coin_o      (coin),
    .coin_busy_o (coin_busy)
  );

  assign p1_ctl = p1_ctl_q;
  assign p2_ctl = p2_ctl_q;
  assign start1 = start1_q;
  assign start2 = start2_q;

endmodule

// File: tb/tb_arcade_input_cond.sv
// Self-checking bench for arcade_input_cond with COIN_PULSE_CYC=4, COIN_GAP_CYC=8.
module tb_arcade_input_cond;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy1    = '0;
  logic [15:0] joy2    = '0;
  logic [5:0]  p1_ctl, p2_ctl;
  logic        start1, start2, coin, coin_busy;

  arcade_input_cond #(
    .COIN_PULSE_CYC (4),
    .COIN_GAP_CYC   (8)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joy1      (joy1),
    .joy2      (joy2),
    .p1_ctl    (p1_ctl),
    .p2_ctl    (p2_ctl),
    .start1    (start1),
    .start2    (start2),
    .coin      (coin),
    .coin_busy (coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] want;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic        ev;
    logic [7:0]  code;
    logic        prs;
    logic        ext;
    logic [5:0]  e1;
    logic [5:0]  e2;
    logic        s1;
    logic        s2;
  } vec_t;
  vec_t vecs[$];

  task automatic expect_val(input string nm, input logic [31:0] want);
    exp_t e;
    e.nm   = nm;
    e.want = want;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] got);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %0h with nothing expected", got);
    end else begin
      e = sb.pop_front();
      if (got !== e.want) begin
        n_errors++;
        $display("FAIL %s: got %0h expected %0h", e.nm, got, e.want);
      end
    end
  endtask

  function automatic logic [13:0] outs_now();
    return {p1_ctl, p2_ctl, start1, start2};
  endfunction

  // Player state as seen on the outputs for the build being simulated.
  function automatic logic [13:0] exp_outs(input logic [5:0] e1, input logic [5:0] e2,
                                           input logic s1, input logic s2);
`ifdef COCKTAIL_SPLIT_EN
    return {e1, e2, s1, s2};
`else
    return {e1 | e2, e1 | e2, s1, s2};
`endif
  endfunction

  task automatic key_evt(input logic [7:0] code, input logic prs, input logic ext);
    ps2_key = {~ps2_key[10], prs, ext, code};
  endtask

  task automatic add_vec(input logic [15:0] j1, input logic [15:0] j2, input logic ev,
                         input logic [7:0] code, input logic prs, input logic ext,
                         input logic [5:0] e1, input logic [5:0] e2,
                         input logic s1, input logic s2);
    vec_t v;
    v.j1 = j1; v.j2 = j2; v.ev = ev; v.code = code; v.prs = prs; v.ext = ext;
    v.e1 = e1; v.e2 = e2; v.s1 = s1; v.s2 = s2;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises, highs, busys, first_hi;
    logic prev;

    // j1, j2, ev, code, prs, ext, e1 (p1 split), e2 (p2 split), s1, s2
    add_vec(16'h0000, 16'h0000, 1, 8'h75, 1, 0, 6'b001000, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h75, 0, 0, 6'b000000, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h99, 1, 0, 6'b000000, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0011, 0, 8'h00, 0, 0, 6'b000000, 6'b010001, 0, 0);
    add_vec(16'h0006, 16'h0000, 0, 8'h00, 0, 0, 6'b000110, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h2D, 1, 0, 6'b000000, 6'b001000, 0, 0);
    add_vec(16'h0000, 16'h0001, 1, 8'h14, 1, 0, 6'b010000, 6'b001001, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h2D, 0, 0, 6'b010000, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h14, 0, 0, 6'b000000, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h6B, 1, 1, 6'b000010, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h6B, 0, 0, 6'b000000, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h05, 1, 0, 6'b000000, 6'b000000, 1, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h16, 1, 0, 6'b000000, 6'b000000, 1, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h16, 0, 0, 6'b000000, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0080, 0, 8'h00, 0, 0, 6'b000000, 6'b000000, 0, 1);
    add_vec(16'h0000, 16'h0000, 1, 8'h06, 1, 0, 6'b000000, 6'b000000, 0, 1);
    add_vec(16'h0000, 16'h0000, 1, 8'h1E, 0, 0, 6'b000000, 6'b000000, 0, 0);
    add_vec(16'h0040, 16'h0000, 0, 8'h00, 0, 0, 6'b000000, 6'b000000, 1, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h11, 1, 0, 6'b100000, 6'b000000, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h34, 1, 0, 6'b100000, 6'b000001, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h11, 0, 0, 6'b000000, 6'b000001, 0, 0);
    add_vec(16'h0000, 16'h0000, 1, 8'h34, 0, 0, 6'b000000, 6'b000000, 0, 0);

    // Reset: outputs held low despite an active joystick; a high toggle
    // level present during reset must not register as an event afterwards.
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    joy1    = 16'h0001;
    repeat (3) @(negedge clk_sys);
    expect_val("reset_outputs", 32'h0);
    check_pop({16'h0, outs_now(), coin, coin_busy});
    reset_n = 1'b1;
    joy1    = 16'h0000;
    repeat (3) @(negedge clk_sys);
    expect_val("post_reset_no_event", 32'h0);
    check_pop({17'h0, outs_now(), coin});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_sys);
      joy1 = vecs[i].j1;
      joy2 = vecs[i].j2;
      if (vecs[i].ev) key_evt(vecs[i].code, vecs[i].prs, vecs[i].ext);
      expect_val($sformatf("vec%0d", i),
                 {18'h0, exp_outs(vecs[i].e1, vecs[i].e2, vecs[i].s1, vecs[i].s2)});
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      check_pop({18'h0, outs_now()});
    end

    // Latency: joystick visible after one edge, key event after two,
    // both applied in the same cycle.
    @(negedge clk_sys);
    key_evt(8'h74, 1'b1, 1'b0);
    joy2 = 16'h0010;
    expect_val("lat_1cyc", {18'h0, exp_outs(6'b000000, 6'b010000, 0, 0)});
    expect_val("lat_2cyc", {18'h0, exp_outs(6'b000001, 6'b010000, 0, 0)});
    @(negedge clk_sys);
    check_pop({18'h0, outs_now()});
    @(negedge clk_sys);
    check_pop({18'h0, outs_now()});
    key_evt(8'h74, 1'b0, 1'b0);
    joy2 = 16'h0000;
    repeat (3) @(negedge clk_sys);
    expect_val("lat_clear", 32'h0);
    check_pop({18'h0, outs_now()});

    // Single coin pulse from joy1, second press lands in GAP.
    rises = 0; highs = 0; busys = 0; first_hi = -1; prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_sys);
      if (coin && !prev) rises++;
      if (coin && first_hi < 0) first_hi = i;
      if (coin) highs++;
      if (coin_busy) busys++;
      prev = coin;
      joy1 = (i == 0 || i == 7) ? 16'h0100 : 16'h0000;
    end
    expect_val("single_rises", 32'd1);
    check_pop(32'(rises));
    expect_val("single_width", 32'd4);
    check_pop(32'(highs));
    expect_val("single_busy", 32'd13);
    check_pop(32'(busys));
    expect_val("single_latency", 32'd1);
    check_pop(32'(first_hi));

    // Coin key 2E held 50 cycles, released, pressed again.
    rises = 0; highs = 0; first_hi = -1; prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_sys);
      if (coin && !prev) rises++;
      if (coin && first_hi < 0) first_hi = i;
      if (coin) highs++;
      prev = coin;
      if (i == 49) begin
        expect_val("held_busy_wait_rel", 32'd1);
        check_pop({31'h0, coin_busy});
      end
      if (i == 54) begin
        expect_val("held_idle_after_rel", 32'd0);
        check_pop({31'h0, coin_busy});
      end
      if (i == 62) begin
        expect_val("held_repress_coin", 32'd1);
        check_pop({31'h0, coin});
      end
      if (i == 0 || i == 60) key_evt(8'h2E, 1'b1, 1'b0);
      if (i == 50 || i == 62) key_evt(8'h2E, 1'b0, 1'b0);
    end
    expect_val("held_rises", 32'd2);
    check_pop(32'(rises));
    expect_val("held_width", 32'd8);
    check_pop(32'(highs));
    expect_val("held_latency", 32'd2);
    check_pop(32'(first_hi));

    // Reset during the second PULSE cycle with the request still held.
    @(negedge clk_sys);
    joy1 = 16'h0100;
    @(negedge clk_sys);
    @(negedge clk_sys);
    expect_val("rst_pulse_before", 32'd1);
    check_pop({31'h0, coin});
    #2 reset_n = 1'b0;
    #1;
    expect_val("rst_async_drop", 32'd0);
    check_pop({31'h0, coin});
    @(negedge clk_sys);
    reset_n = 1'b1;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      if (coin && !prev) rises++;
      prev = coin;
    end
    expect_val("rst_held_no_pulse", 32'd0);
    check_pop(32'(rises));
    expect_val("rst_held_busy", 32'd1);
    check_pop({31'h0, coin_busy});
    joy1 = 16'h0000;
    @(negedge clk_sys);
    expect_val("rst_release_idle", 32'd0);
    check_pop({31'h0, coin_busy});
    joy1 = 16'h0100;
    @(negedge clk_sys);
    expect_val("rst_repress_coin", 32'd1);
    check_pop({31'h0, coin});
    joy1 = 16'h0000;
    repeat (20) @(negedge clk_sys);

    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, 0 expected", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
